// File: rtl/button_conditioner.sv
// Synchronise, debounce and edge-detect the right/left/drop push-buttons into single-cycle strobes.
// Define BUTTON_AUTO_REPEAT_EN to build the shared left/right auto-repeat FSM.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 7500000,
    parameter int REPEAT_PERIOD   = 2500000,
    parameter int CNT_W           = 23
) (
    input  logic       clk_25MHz,
    input  logic       rst_n,
    input  logic       btn_right_raw,
    input  logic       btn_left_raw,
    input  logic       btn_drop_raw,
    output logic       move_right,
    output logic       move_left,
    output logic       drop_piece,
    output logic [2:0] btn_level
);

    localparam int CH_RIGHT = 0;
    localparam int CH_LEFT  = 1;
    localparam int CH_DROP  = 2;
    localparam int NUM_CH   = 3;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_CH-1:0] w_raw;
    logic [NUM_CH-1:0] r_sync1;
    logic [NUM_CH-1:0] r_sync2;
    logic [NUM_CH-1:0] r_level;
    logic [NUM_CH-1:0] r_level_d;
    logic [NUM_CH-1:0] w_flip;
    logic [NUM_CH-1:0] w_rise;
    logic [CNT_W-1:0]  r_deb_cnt [NUM_CH];
    logic              w_fire_right;
    logic              w_fire_left;
    logic              r_move_right;
    logic              r_move_left;
    logic              r_drop_piece;

    assign w_raw = {btn_drop_raw, btn_left_raw, btn_right_raw};

    // NOTE: flops use non-blocking assignment so every stage samples the pre-edge value of the one before it.
    always_ff @(posedge clk_25MHz) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_flip = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w_flip[ch] = (r_sync2[ch] != r_level[ch]) && (r_deb_cnt[ch] == DEB_LAST);
        end
    end

    always_ff @(posedge clk_25MHz) begin
        if (!rst_n) begin
            r_level   <= '0;
            r_level_d <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_deb_cnt[ch] <= '0;
            end
        end else begin
            r_level_d <= r_level;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (r_sync2[ch] == r_level[ch]) begin
                    r_deb_cnt[ch] <= '0;
                end else if (w_flip[ch]) begin
                    r_level[ch]   <= r_sync2[ch];
                    r_deb_cnt[ch] <= '0;
                end else begin
                    r_deb_cnt[ch] <= r_deb_cnt[ch] + CNT_W'(1);
                end
            end
        end
    end

    // A move press is dropped while the opposite button is held down.
    assign w_rise       = r_level & ~r_level_d;
    assign w_fire_right = w_rise[CH_RIGHT] & ~r_level[CH_LEFT];
    assign w_fire_left  = w_rise[CH_LEFT]  & ~r_level[CH_RIGHT];

    always_ff @(posedge clk_25MHz) begin
        if (!rst_n) begin
            r_drop_piece <= 1'b0;
        end else begin
            r_drop_piece <= w_rise[CH_DROP];
        end
    end

`ifdef BUTTON_AUTO_REPEAT_EN

    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } rpt_state_t;

    rpt_state_t        r_state;
    logic [CNT_W-1:0]  r_rpt_cnt;
    logic              r_dir;
    logic [NUM_CH-1:0] w_level_nxt;
    logic              w_abort;
    logic              w_rep_ok;
    logic              w_at_last;

    // Abort looks at the level being loaded this edge, so a release wins over a coincident repeat.
    assign w_level_nxt = r_level ^ w_flip;
    assign w_abort     = r_dir ? (~w_level_nxt[CH_LEFT]  | w_level_nxt[CH_RIGHT])
                               : (~w_level_nxt[CH_RIGHT] | w_level_nxt[CH_LEFT]);
    assign w_rep_ok    = r_dir ? ~r_level[CH_RIGHT] : ~r_level[CH_LEFT];
    assign w_at_last   = (r_rpt_cnt == ((r_state == ST_DELAY) ? DLY_LAST : PER_LAST));

    always_ff @(posedge clk_25MHz) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_rpt_cnt    <= '0;
            r_dir        <= 1'b0;
            r_move_right <= 1'b0;
            r_move_left  <= 1'b0;
        end else begin
            r_move_right <= w_fire_right;
            r_move_left  <= w_fire_left;
            case (r_state)
                ST_IDLE: begin
                    if (w_fire_right || w_fire_left) begin
                        r_state   <= ST_DELAY;
                        r_dir     <= w_fire_left;
                        r_rpt_cnt <= '0;
                    end
                end
                ST_DELAY, ST_REPEAT: begin
                    if (w_abort) begin
                        r_state   <= ST_IDLE;
                        r_rpt_cnt <= '0;
                    end else if (w_at_last) begin
                        r_state   <= ST_REPEAT;
                        r_rpt_cnt <= '0;
                        if (r_dir) begin
                            r_move_left <= w_rep_ok;
                        end else begin
                            r_move_right <= w_rep_ok;
                        end
                    end else begin
                        r_rpt_cnt <= r_rpt_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_rpt_cnt <= '0;
                end
            endcase
        end
    end

`else

    logic [CNT_W-1:0] w_unused_cfg;
    assign w_unused_cfg = CNT_W'(REPEAT_DELAY) ^ CNT_W'(REPEAT_PERIOD);

    always_ff @(posedge clk_25MHz) begin
        if (!rst_n) begin
            r_move_right <= 1'b0;
            r_move_left  <= 1'b0;
        end else begin
            r_move_right <= w_fire_right;
            r_move_left  <= w_fire_left;
        end
    end

`endif

    assign move_right = r_move_right;
    assign move_left  = r_move_left;
    assign drop_piece = r_drop_piece;
    assign btn_level  = r_level;

endmodule
